// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: widths, FSM states, next-PC source codes.
// Also holds the fetch-handshake helper used by the FSM and the instr_valid register.
package pc_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PC_WIDTH   = DEF_DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERR   = 2'd3
  } pcState_t;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_ALU  = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  // A fetch completes on the FETCH cycle that sees the memory acknowledge.
  function automatic logic fetchDone(input pcState_t s, input logic ack);
    return (s == ST_FETCH) && ack;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control and instruction-fetch signal bundle between the sequencer and pc_unit.
// The sequencer side drives the control inputs and the memory acknowledge.
interface pc_unit_if
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PC_WIDTH   = DATA_WIDTH / 2
);

  logic                  start;
  logic                  pc_write;
  logic [1:0]            pc_src;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [PC_WIDTH-1:0]   jump_target;
  logic                  imem_ack;
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [PC_WIDTH-1:0]   pc_out;
  logic                  instr_valid;
  logic                  addr_err;

  modport master (
    output start, pc_write, pc_src, alu_result, jump_target, imem_ack,
    input  imem_req, imem_addr, pc_out, instr_valid, addr_err
  );

  modport slave (
    input  start, pc_write, pc_src, alu_result, jump_target, imem_ack,
    output imem_req, imem_addr, pc_out, instr_valid, addr_err
  );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selector with the ALU-target range check.
// range_err flags an ALU branch target whose upper bits do not fit in the PC.
module pc_next_logic
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PC_WIDTH   = DEF_PC_WIDTH
) (
  input  logic [PC_WIDTH-1:0]   pcCur,
  input  logic [1:0]            pcSrc,
  input  logic [DATA_WIDTH-1:0] aluResult,
  input  logic [PC_WIDTH-1:0]   jumpTarget,
  output logic [PC_WIDTH-1:0]   next_pc,
  output logic                  range_err
);

  logic upperBits;

  generate
    if (DATA_WIDTH > PC_WIDTH) begin : gUpper
      assign upperBits = |aluResult[DATA_WIDTH-1:PC_WIDTH];
    end else begin : gNoUpper
      assign upperBits = 1'b0;
    end
  endgenerate

  always_comb begin
    next_pc = pcCur;
    unique case (pcSrc)
      PC_INC:  next_pc = pcCur + PC_WIDTH'(1);
      PC_ALU:  next_pc = aluResult[PC_WIDTH-1:0];
      PC_JUMP: next_pc = jumpTarget;
      PC_HOLD: next_pc = pcCur;
      default: next_pc = pcCur;
    endcase
  end

  assign range_err = (pcSrc == PC_ALU) && upperBits;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: IDLE/FETCH/EXEC/ERR sequencer, PC register and fetch handshake.
// The fetch address is the PC itself; an out-of-range ALU target parks the unit in ERR.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                  PC_WIDTH   = DATA_WIDTH / 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(16'h0000)
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_unit_if.slave   bus
);

  pcState_t            state;
  pcState_t            stateNext;
  logic [PC_WIDTH-1:0] pcReg;
  logic [PC_WIDTH-1:0] nextPc;
  logic                rangeErr;
  logic                pcLoad;
  logic                errSet;
  logic                instrValid;
  logic                addrErr;

  pc_next_logic #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) uNextLogic (
    .pcCur      (pcReg),
    .pcSrc      (bus.pc_src),
    .aluResult  (bus.alu_result),
    .jumpTarget (bus.jump_target),
    .next_pc    (nextPc),
    .range_err  (rangeErr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // start, pc_write and imem_ack only matter in the state that consumes them.
  always_comb begin
    stateNext = state;
    pcLoad    = 1'b0;
    errSet    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) stateNext = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetchDone(state, bus.imem_ack)) stateNext = ST_EXEC;
      end
      ST_EXEC: begin
        if (bus.pc_write) begin
          if (rangeErr) begin
            errSet    = 1'b1;
            stateNext = ST_ERR;
          end else begin
            pcLoad    = 1'b1;
            stateNext = ST_FETCH;
          end
        end
      end
      ST_ERR: begin
        stateNext = ST_ERR;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg      <= RESET_PC;
      instrValid <= 1'b0;
      addrErr    <= 1'b0;
    end else begin
      instrValid <= fetchDone(state, bus.imem_ack);
      if (pcLoad) pcReg <= nextPc;
      if (errSet) addrErr <= 1'b1;
    end
  end

  assign bus.imem_req    = (state == ST_FETCH);
  assign bus.imem_addr   = pcReg;
  assign bus.pc_out      = pcReg;
  assign bus.instr_valid = instrValid;
  assign bus.addr_err    = addrErr;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, reset corner sequences and a randomized run
// against a transaction-level model of the PC sequencing rules.
module tb_pc_unit;

  localparam int DW = 32;
  localparam int PW = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_EXEC  = 2;
  localparam int PH_HALT  = 3;

  typedef struct {
    string       name;
    logic        start;
    logic        pcw;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [15:0] jt;
    logic        ack;
    logic        expReq;
    logic [15:0] expAddr;
    logic        expValid;
    logic        expErr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   nVec;
  int   nBad;

  int   mPhase;
  int   mPc;
  bit   mErr;
  bit   mValid;

  vec_t tbl[$];

  pc_unit_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) bus ();

  pc_unit #(
    .DATA_WIDTH (DW),
    .PC_WIDTH   (PW),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkOutputs(input string tag, input logic req, input logic [15:0] addr,
                            input logic valid, input logic err);
    chk({tag, ".imem_req"},    32'(bus.imem_req),    32'(req));
    chk({tag, ".imem_addr"},   32'(bus.imem_addr),   32'(addr));
    chk({tag, ".pc_out"},      32'(bus.pc_out),      32'(addr));
    chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(valid));
    chk({tag, ".addr_err"},    32'(bus.addr_err),    32'(err));
  endtask

  task automatic clearInputs();
    bus.start       = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 2'b00;
    bus.alu_result  = 32'h0;
    bus.jump_target = 16'h0;
    bus.imem_ack    = 1'b0;
  endtask

  function automatic vec_t mk(input string n, input logic s, input logic w, input logic [1:0] src,
                              input logic [31:0] alu, input logic [15:0] jt, input logic ack,
                              input logic req, input logic [15:0] addr, input logic v,
                              input logic e);
    vec_t r;
    r.name = n; r.start = s; r.pcw = w; r.src = src; r.alu = alu; r.jt = jt; r.ack = ack;
    r.expReq = req; r.expAddr = addr; r.expValid = v; r.expErr = e;
    return r;
  endfunction

  // Reference: what one clock edge does, stated as the sequencing rules on a PC value.
  task automatic modelStep();
    int nPhase;
    int nPc;
    bit nErr;
    nPhase = mPhase;
    nPc    = mPc;
    nErr   = mErr;
    mValid = (mPhase == PH_FETCH) && (bus.imem_ack == 1'b1);
    case (mPhase)
      PH_IDLE:  if (bus.start) nPhase = PH_FETCH;
      PH_FETCH: if (bus.imem_ack) nPhase = PH_EXEC;
      PH_EXEC: begin
        if (bus.pc_write) begin
          if (bus.pc_src == 2'd1 && (bus.alu_result / 65536) != 0) begin
            nErr   = 1'b1;
            nPhase = PH_HALT;
          end else begin
            case (bus.pc_src)
              2'd0:    nPc = (mPc + 1) % 65536;
              2'd1:    nPc = int'(bus.alu_result % 65536);
              2'd2:    nPc = int'(bus.jump_target);
              default: nPc = mPc;
            endcase
            nPhase = PH_FETCH;
          end
        end
      end
      default: ;
    endcase
    mPhase = nPhase;
    mPc    = nPc;
    mErr   = nErr;
  endtask

  task automatic modelReset();
    mPhase = PH_IDLE;
    mPc    = 0;
    mErr   = 1'b0;
    mValid = 1'b0;
  endtask

  initial begin
    nVec = 0;
    nBad = 0;
    rst_n = 1'b1;
    clearInputs();

    tbl.push_back(mk("idle",         0, 0, 2'd0, 32'h0,          16'h0,    0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk("idle_pcw",     0, 1, 2'd2, 32'h0,          16'h5555, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk("start",        1, 0, 2'd0, 32'h0,          16'h0,    0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk("fetch2",       0, 0, 2'd0, 32'h0,          16'h0,    0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk("fetch3_pcw",   0, 1, 2'd2, 32'h0,          16'h7777, 0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk("ack3",         0, 0, 2'd0, 32'h0,          16'h0,    1, 0, 16'h0000, 1, 0));
    tbl.push_back(mk("exec_hold",    0, 0, 2'd0, 32'h0,          16'h0,    0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk("exec_start",   1, 0, 2'd0, 32'h0,          16'h0,    1, 0, 16'h0000, 0, 0));
    tbl.push_back(mk("jump5",        0, 1, 2'd2, 32'h0,          16'h0005, 0, 1, 16'h0005, 0, 0));
    tbl.push_back(mk("ack_5",        0, 0, 2'd0, 32'h0,          16'h0,    1, 0, 16'h0005, 1, 0));
    tbl.push_back(mk("inc_6",        0, 1, 2'd0, 32'h0,          16'h0,    0, 1, 16'h0006, 0, 0));
    tbl.push_back(mk("ack_6",        0, 0, 2'd0, 32'h0,          16'h0,    1, 0, 16'h0006, 1, 0));
    tbl.push_back(mk("jumpFFFF",     0, 1, 2'd2, 32'h0,          16'hFFFF, 0, 1, 16'hFFFF, 0, 0));
    tbl.push_back(mk("ack_FFFF",     0, 0, 2'd0, 32'h0,          16'h0,    1, 0, 16'hFFFF, 1, 0));
    tbl.push_back(mk("inc_wrap",     0, 1, 2'd0, 32'h0,          16'h0,    0, 1, 16'h0000, 0, 0));
    tbl.push_back(mk("ack_0",        0, 0, 2'd0, 32'h0,          16'h0,    1, 0, 16'h0000, 1, 0));
    tbl.push_back(mk("alu_1234",     0, 1, 2'd1, 32'h0000_1234,  16'h0,    0, 1, 16'h1234, 0, 0));
    tbl.push_back(mk("ack_1234",     0, 0, 2'd0, 32'h0,          16'h0,    1, 0, 16'h1234, 1, 0));
    tbl.push_back(mk("src3_hold",    0, 1, 2'd3, 32'h0,          16'hAAAA, 0, 1, 16'h1234, 0, 0));
    tbl.push_back(mk("ack_hold",     0, 0, 2'd0, 32'h0,          16'h0,    1, 0, 16'h1234, 1, 0));
    tbl.push_back(mk("jumpBEEF",     0, 1, 2'd2, 32'h0,          16'hBEEF, 0, 1, 16'hBEEF, 0, 0));
    tbl.push_back(mk("ack_BEEF",     0, 0, 2'd0, 32'h0,          16'h0,    1, 0, 16'hBEEF, 1, 0));
    tbl.push_back(mk("alu_range",    0, 1, 2'd1, 32'h0001_1234,  16'h0,    0, 0, 16'hBEEF, 0, 1));
    tbl.push_back(mk("err_start",    1, 0, 2'd0, 32'h0,          16'h0,    1, 0, 16'hBEEF, 0, 1));
    tbl.push_back(mk("err_pcw",      1, 1, 2'd0, 32'h0,          16'h0,    1, 0, 16'hBEEF, 0, 1));

    // Asynchronous reset with no clock edge involved.
    #2 rst_n = 1'b0;
    #1 chkOutputs("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      bus.start       = tbl[i].start;
      bus.pc_write    = tbl[i].pcw;
      bus.pc_src      = tbl[i].src;
      bus.alu_result  = tbl[i].alu;
      bus.jump_target = tbl[i].jt;
      bus.imem_ack    = tbl[i].ack;
      @(negedge clk);
      chkOutputs(tbl[i].name, tbl[i].expReq, tbl[i].expAddr, tbl[i].expValid, tbl[i].expErr);
    end
    clearInputs();

    // Reset out of ERR clears the sticky error between clock edges.
    #2 rst_n = 1'b0;
    #1 chkOutputs("rst_in_err", 1'b0, 16'h0000, 1'b0, 1'b0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = 1'b1;
      @(negedge clk);
      chkOutputs("post_rst_idle", 1'b0, 16'h0000, 1'b0, 1'b0);
    end
    bus.imem_ack = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    chkOutputs("re_start", 1'b1, 16'h0000, 1'b0, 1'b0);
    bus.start = 1'b0;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    chkOutputs("re_ack", 1'b0, 16'h0000, 1'b1, 1'b0);
    bus.imem_ack = 1'b0;
    bus.pc_write = 1'b1;
    bus.pc_src = 2'd2;
    bus.jump_target = 16'h00A0;
    @(negedge clk);
    chkOutputs("fetch_A0", 1'b1, 16'h00A0, 1'b0, 1'b0);
    clearInputs();

    // Reset in the middle of a fetch drops the request and the PC at once.
    #2 rst_n = 1'b0;
    #1 chkOutputs("rst_mid_fetch", 1'b0, 16'h0000, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    chkOutputs("fetch_discarded", 1'b0, 16'h0000, 1'b0, 1'b0);
    clearInputs();

    modelReset();
    for (int c = 0; c < 2000; c++) begin
      chkOutputs("rand", (mPhase == PH_FETCH), 16'(mPc), mValid, mErr);
      if ($urandom_range(0, 29) == 0) begin
        clearInputs();
        #2 rst_n = 1'b0;
        #1 chkOutputs("rand_rst", 1'b0, 16'h0000, 1'b0, 1'b0);
        modelReset();
        #1 rst_n = 1'b1;
      end else begin
        bus.start       = ($urandom_range(0, 2) == 0);
        bus.imem_ack    = ($urandom_range(0, 1) == 0);
        bus.pc_write    = ($urandom_range(0, 2) == 0);
        bus.pc_src      = 2'($urandom_range(0, 3));
        bus.jump_target = 16'($urandom);
        bus.alu_result  = ($urandom_range(0, 5) == 0) ? 32'($urandom) : {16'h0, 16'($urandom)};
      end
      modelStep();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath word width.
REQ-002 Parameter PC_WIDTH, default DATA_WIDTH/2, program counter width; it matches the zero-extended PC operand path of the ALU.
REQ-003 Parameter RESET_PC, default 16'h0000, PC value loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse that begins fetching from the current PC.
REQ-007 pc_write  input  1  control strobe that commits the next PC.
REQ-008 pc_src  input  2  next-PC select: 00 increment, 01 ALU result, 10 jump target, 11 reserved.
REQ-009 alu_result  input  DATA_WIDTH  ALU output carrying the branch target.
REQ-010 jump_target  input  PC_WIDTH  absolute jump address.
REQ-011 imem_ack  input  1  instruction memory accepted the request.
REQ-012 imem_req  output  1  instruction fetch request.
REQ-013 imem_addr  output  PC_WIDTH  fetch address, equal to pc_out.
REQ-014 pc_out  output  PC_WIDTH  current PC, feeds the ALU source-A operand path.
REQ-015 instr_valid  output  1  one-cycle pulse on the cycle after the fetch handshake completes.
REQ-016 addr_err  output  1  sticky error: the branch target does not fit in PC_WIDTH.

Function
REQ-017 The block SHALL implement the states IDLE, FETCH, EXEC and ERR.
REQ-018 IDLE SHALL move to FETCH on start=1; otherwise it SHALL stay in IDLE; pc_write SHALL be ignored in IDLE.
REQ-019 FETCH SHALL drive imem_req=1 and imem_addr=pc_out, holding both stable until a cycle with imem_ack=1, then move to EXEC.
REQ-020 instr_valid SHALL be 1 for exactly the first cycle in EXEC.
REQ-021 EXEC SHALL hold the PC until pc_write=1, then load the next PC and return to FETCH on the following edge.
REQ-022 Next PC SHALL be: pc_src 00 -> pc_out+1 modulo 2^PC_WIDTH (16'hFFFF wraps to 16'h0000); 01 -> alu_result[PC_WIDTH-1:0]; 10 -> jump_target; 11 -> pc_out unchanged.
REQ-023 With pc_src=01 and alu_result[DATA_WIDTH-1:PC_WIDTH] nonzero, pc_write SHALL leave the PC unchanged, set addr_err and enter ERR.
REQ-024 ERR SHALL keep imem_req=0 and instr_valid=0, and SHALL ignore start and pc_write; only reset exits ERR.
REQ-025 pc_write in FETCH and start outside IDLE SHALL be ignored.
REQ-026 imem_ack outside FETCH SHALL be ignored.
REQ-027 Latency SHALL be: start to imem_req=1 in 1 cycle; imem_ack to instr_valid in 1 cycle; pc_write to new imem_addr with imem_req=1 in 1 cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, pc_out=RESET_PC, imem_req=0, instr_valid=0 and addr_err=0, independent of clk.
REQ-029 Reset asserted mid-fetch SHALL drop imem_req in the same cycle; the interrupted fetch SHALL be discarded.
REQ-030 After reset release, the block SHALL stay in IDLE until start.

Structure
REQ-031 Package pc_pkg SHALL hold the state encoding, the pc_src codes (PC_INC, PC_ALU, PC_JUMP) and the default widths.
REQ-032 Next-PC selection and range check SHALL be one combinational sub-module, pc_next_logic (outputs next_pc and range_err); the FSM and PC register SHALL be in pc_unit.

Verification
REQ-033 Reset, then start, imem_ack on the 3rd FETCH cycle -> imem_addr=0x0000 stable for 3 cycles, instr_valid one pulse, no PC change.
REQ-034 PC=0x0005, pc_write with pc_src=00 -> imem_addr=0x0006 next cycle; PC=0xFFFF with pc_src=00 -> 0x0000.
REQ-035 pc_src=01, alu_result=0x0000_1234 -> PC=0x1234; alu_result=0x0001_1234 -> PC unchanged, addr_err=1, imem_req=0, further start ignored.
REQ-036 pc_src=10, jump_target=0xBEEF -> PC=0xBEEF; pc_write pulsed during FETCH -> ignored, imem_addr unchanged.
REQ-037 rst_n asserted low while imem_req=1 -> imem_req=0 and pc_out=RESET_PC before the next clk edge; addr_err cleared after a prior error.
